// File: rtl/clock_ctrl_pkg.sv
// Shared types and default constants for the clock power-mode sequencer.
// The state encoding is visible on the debug port, so the values are fixed.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_WAKE      = 3'd1,
        ST_RUN       = 3'd2,
        ST_LSI_START = 3'd3,
        ST_SLEEP     = 3'd4
    } state_t;

    localparam int DEF_PLL_LOCK_CYCLES   = 16;
    localparam int DEF_LSI_SETTLE_CYCLES = 8;
    localparam int DEF_WDT_TIMEOUT       = 200;
    localparam int DEF_CNT_W             = 8;

    typedef struct packed {
        logic clk_enable;
        logic lsi_enable;
        logic pll_sel;
        logic sleep_ack;
    } clk_outs_t;

    // Moore decode: the generator controls are a pure function of the state.
    function automatic clk_outs_t state_outputs(input state_t st);
        clk_outs_t outs;
        outs = '0;
        case (st)
            ST_BOOT:      outs = 4'b0000;
            ST_WAKE:      outs = 4'b1000;
            ST_RUN:       outs = 4'b1010;
            ST_LSI_START: outs = 4'b1110;
            ST_SLEEP:     outs = 4'b0101;
            default:      outs = 4'b0000;
        endcase
        return outs;
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Request/status bundle between the power manager and the clock sequencer.
// master is the sequencer side, slave is the power-manager side.
interface clock_ctrl_if;
    import clock_ctrl_pkg::*;

    logic   sleep_req;
    logic   wake_evt;
    logic   wdt_kick;
    logic   clk_enable;
    logic   lsi_enable;
    logic   pll_sel;
    logic   sleep_ack;
    logic   wdt_bite;
    state_t state;

    modport master (
        input  sleep_req,
        input  wake_evt,
        input  wdt_kick,
        output clk_enable,
        output lsi_enable,
        output pll_sel,
        output sleep_ack,
        output wdt_bite,
        output state
    );

    modport slave (
        output sleep_req,
        output wake_evt,
        output wdt_kick,
        input  clk_enable,
        input  lsi_enable,
        input  pll_sel,
        input  sleep_ack,
        input  wdt_bite,
        input  state
    );

endinterface

// File: rtl/clock_ctrl_wdt_counter.sv
// Cycle-counting watchdog. o_expire is the same-cycle terminal condition the
// sequencer needs to pick BOOT; o_bite is its registered one-cycle copy.
module wdt_counter #(
    parameter int CNT_W       = 8,
    parameter int WDT_TIMEOUT = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_kick,
    input  logic i_clear,
    output logic o_expire,
    output logic o_bite
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(WDT_TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bite;

    // A kick on the terminal cycle wins over the bite.
    assign o_expire = i_run && !i_kick && (r_cnt == TERM_CNT);
    assign o_bite   = r_bite;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_bite <= 1'b0;
        end else begin
            r_bite <= o_expire;
            if (i_clear || i_kick || o_expire) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Power-mode sequencer for the system clock generator. Every output is a flop
// loaded from the next-state decode, so outputs change exactly with the state.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int PLL_LOCK_CYCLES   = DEF_PLL_LOCK_CYCLES,
    parameter int LSI_SETTLE_CYCLES = DEF_LSI_SETTLE_CYCLES,
    parameter int WDT_TIMEOUT       = DEF_WDT_TIMEOUT,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    clock_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LSI_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    clk_outs_t        r_outs;
    clk_outs_t        w_outs_next;
    logic             w_phase_cnt;
    logic             w_wdt_run;
    logic             w_wdt_clear;
    logic             w_wdt_expire;
    logic             w_wdt_bite;

    assign w_wdt_run   = (r_state == ST_RUN) || (r_state == ST_LSI_START);
    assign w_wdt_clear = !w_wdt_run;
    assign w_phase_cnt = (r_state == ST_WAKE) || (r_state == ST_LSI_START);

    wdt_counter #(
        .CNT_W       (CNT_W),
        .WDT_TIMEOUT (WDT_TIMEOUT)
    ) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .i_run    (w_wdt_run),
        .i_kick   (bus.wdt_kick),
        .i_clear  (w_wdt_clear),
        .o_expire (w_wdt_expire),
        .o_bite   (w_wdt_bite)
    );

    // Bite outranks wake, wake outranks sleep.
    always_comb begin
        w_state_next = r_state;
        if (w_wdt_expire) begin
            w_state_next = ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_state_next = ST_WAKE;
                end
                ST_WAKE: begin
                    if (r_cnt == LOCK_LAST) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.sleep_req && !bus.wake_evt) begin
                        w_state_next = ST_LSI_START;
                    end
                end
                ST_LSI_START: begin
                    if (bus.wake_evt) begin
                        w_state_next = ST_RUN;
                    end else if (r_cnt == SETTLE_LAST) begin
                        w_state_next = ST_SLEEP;
                    end
                end
                ST_SLEEP: begin
                    if (bus.wake_evt) begin
                        w_state_next = ST_WAKE;
                    end
                end
                default: begin
                    w_state_next = ST_BOOT;
                end
            endcase
        end
    end

    // Phase counter restarts on every transition and saturates rather than wraps.
    always_comb begin
        w_cnt_next = '0;
        if ((w_state_next == r_state) && w_phase_cnt) begin
            w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    assign w_outs_next = state_outputs(w_state_next);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
            r_cnt   <= '0;
            r_outs  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_outs  <= w_outs_next;
        end
    end

    assign bus.clk_enable = r_outs.clk_enable;
    assign bus.lsi_enable = r_outs.lsi_enable;
    assign bus.pll_sel    = r_outs.pll_sel;
    assign bus.sleep_ack  = r_outs.sleep_ack;
    assign bus.wdt_bite   = w_wdt_bite;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: timed expectations are queued when stimulus
// is scheduled and compared on the falling edge of the cycle they belong to.
module tb_clock_ctrl;
    import clock_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clock_ctrl_if bus();

    clock_ctrl #(
        .PLL_LOCK_CYCLES   (16),
        .LSI_SETTLE_CYCLES (8),
        .WDT_TIMEOUT       (200),
        .CNT_W             (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge number since the last reset release; edge 1 is the first after release.
    int unsigned cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Observed vector: {state[2:0], clk_enable, lsi_enable, pll_sel, sleep_ack, wdt_bite}
    logic [7:0] w_obs;
    assign w_obs = {3'(bus.state), bus.clk_enable, bus.lsi_enable, bus.pll_sel,
                    bus.sleep_ack, bus.wdt_bite};

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [7:0]  vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("[%0t] %s ok %0h", $time, tag, got);
        end
    endtask

    // Expected output table, written from the state/output list.
    function automatic logic [7:0] ev(input logic [2:0] st, input logic bite);
        logic [3:0] o;
        case (st)
            3'd1:    o = 4'b1000;
            3'd2:    o = 4'b1010;
            3'd3:    o = 4'b1110;
            3'd4:    o = 4'b0101;
            default: o = 4'b0000;
        endcase
        return {st, o, bite};
    endfunction

    task automatic expect_at(input int unsigned c, input string tag,
                             input logic [2:0] st, input logic bite);
        exp_t e;
        e.cyc = c;
        e.tag = $sformatf("%s@%0d", tag, c);
        e.vec = ev(st, bite);
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc == cyc)
                    check_vec(mon_e.tag, 32'(w_obs), 32'(mon_e.vec));
                else
                    check_vec({mon_e.tag, "_missed"}, cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: time %0t exceeded limit 200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.sleep_req = 1'b0;
        bus.wake_evt  = 1'b0;
        bus.wdt_kick  = 1'b0;

        // Reset state, including asynchronous entry before any clock edge.
        #2 reset = 1'b0;
        #1 check_vec("rst_async", 32'(w_obs), 32'(ev(3'd0, 1'b0)));
        repeat (2) @(negedge clk);
        check_vec("rst_hold", 32'(w_obs), 32'(ev(3'd0, 1'b0)));

        // Boot sequence: WAKE at edge 1, RUN at edge 17.
        expect_at(1,  "boot_wake", 3'd1, 1'b0);
        expect_at(16, "boot_lock", 3'd1, 1'b0);
        expect_at(17, "boot_run",  3'd2, 1'b0);
        reset = 1'b1;

        // Sleep entry, wake, held-request re-entry, then abort on the 4th LSI cycle.
        expect_at(21, "slp_lsi",     3'd3, 1'b0);
        expect_at(28, "slp_settle",  3'd3, 1'b0);
        expect_at(29, "slp_sleep",   3'd4, 1'b0);
        expect_at(35, "slp_hold",    3'd4, 1'b0);
        expect_at(36, "wk_wake",     3'd1, 1'b0);
        expect_at(51, "wk_lock",     3'd1, 1'b0);
        expect_at(52, "wk_run",      3'd2, 1'b0);
        expect_at(53, "reslp_lsi",   3'd3, 1'b0);
        expect_at(56, "abort_pre",   3'd3, 1'b0);
        expect_at(57, "abort_run",   3'd2, 1'b0);
        expect_at(60, "abort_stay",  3'd2, 1'b0);
        wait_cyc(20); bus.sleep_req = 1'b1;
        wait_cyc(35); bus.wake_evt  = 1'b1;
        wait_cyc(36); bus.wake_evt  = 1'b0;
        wait_cyc(53); bus.sleep_req = 1'b0;
        wait_cyc(56); bus.wake_evt  = 1'b1;
        wait_cyc(57); bus.wake_evt  = 1'b0; bus.wdt_kick = 1'b1;
        wait_cyc(58); bus.wdt_kick  = 1'b0;

        // Watchdog: bite 201 edges after the last kick, and after entering RUN.
        expect_at(258,  "wdt_pre",    3'd2, 1'b0);
        expect_at(259,  "wdt_bite",   3'd0, 1'b1);
        expect_at(260,  "wdt_wake",   3'd1, 1'b0);
        expect_at(276,  "wdt_rerun",  3'd2, 1'b0);
        expect_at(476,  "wdt2_pre",   3'd2, 1'b0);
        expect_at(477,  "wdt2_bite",  3'd0, 1'b1);
        expect_at(478,  "wdt2_wake",  3'd1, 1'b0);
        expect_at(494,  "wdt2_run",   3'd2, 1'b0);
        // Kick on the exact terminal cycle, then every 100 cycles for 1000 cycles.
        expect_at(694,  "term_pre",   3'd2, 1'b0);
        expect_at(695,  "term_kick",  3'd2, 1'b0);
        expect_at(696,  "term_after", 3'd2, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            expect_at(694 + 100 * k, $sformatf("kick%0d_pre", k), 3'd2, 1'b0);
            expect_at(695 + 100 * k, $sformatf("kick%0d", k),     3'd2, 1'b0);
        end
        expect_at(1895, "late_pre",  3'd2, 1'b0);
        expect_at(1896, "late_bite", 3'd0, 1'b1);
        expect_at(1897, "late_wake", 3'd1, 1'b0);
        wait_cyc(694); bus.wdt_kick = 1'b1;
        wait_cyc(695); bus.wdt_kick = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(694 + 100 * k); bus.wdt_kick = 1'b1;
            wait_cyc(695 + 100 * k); bus.wdt_kick = 1'b0;
        end

        // Reset mid-WAKE: immediate return to reset values, full lock wait again.
        wait_cyc(1900);
        check_vec("mid_wake_state", 32'(w_obs), 32'(ev(3'd1, 1'b0)));
        #2 reset = 1'b0;
        #1 check_vec("rst_mid_async", 32'(w_obs), 32'(ev(3'd0, 1'b0)));
        @(negedge clk);
        check_vec("rst_mid_hold", 32'(w_obs), 32'(ev(3'd0, 1'b0)));
        expect_at(1,  "rewake",  3'd1, 1'b0);
        expect_at(16, "relock",  3'd1, 1'b0);
        expect_at(17, "rerun",   3'd2, 1'b0);
        reset = 1'b1;
        wait_cyc(18);
        repeat (2) @(negedge clk);
        check_vec("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
